// File: rtl/vme_pkg.sv
// Shared VME slave definitions: state codes, address modifiers
// and the bit positions of the fields decoded from A[23:1].
package vme_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LATCH   = 3'd1;
  localparam logic [2:0] ST_STRB    = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_BERR    = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  localparam logic [5:0] AM_A24_NP  = 6'h39;
  localparam logic [5:0] AM_A24_SUP = 6'h3D;

  localparam int CMD_LSB  = 2;
  localparam int CMD_MSB  = 11;
  localparam int DEV_LSB  = 12;
  localparam int DEV_MSB  = 15;
  localparam int SLOT_LSB = 19;
  localparam int SLOT_MSB = 23;

  function automatic logic am_ok(input logic [5:0] am);
    return (am == AM_A24_NP) || (am == AM_A24_SUP);
  endfunction

endpackage

// File: rtl/vme_sync.sv
// Multi-flop synchronizer for one asynchronous VME control line.
// Resets to 1 so every active-low strobe reads inactive.
module vme_sync #(
  parameter int STAGES = 2
) (
  input  logic FASTCLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift the raw input through STAGES flops
  always_ff @(posedge FASTCLK or posedge RST) begin
    if (RST) ff <= '1;
    else     ff <= (ff << 1) | STAGES'(d);
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/vme_slave_decode.sv
// VME A24 slave decoder: slot/AM qualification, one-hot device
// strobe, DTACK pass-through wait and bus-error timeout.
module vme_slave_decode
  import vme_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic        FASTCLK,
  input  logic        RST,
  input  logic [4:0]  GA,
  input  logic        AS_B,
  input  logic        DS0_B,
  input  logic        DS1_B,
  input  logic        VME_WRITE_B,
  input  logic [5:0]  AM,
  input  logic [23:1] ADR,
  input  logic        DTACK_IN_B,
  output logic        STROBE,
  output logic        WRITE_B,
  output logic [15:0] DEVICE,
  output logic [9:0]  COMMAND,
  output logic        BERR_B,
  output logic        BUSY
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic as_s, ds0_s, ds1_s, dtack_s;
  logic as_act, ds_act, dtack_act;
  logic [2:0] state;
  logic [15:0] cnt;
  logic [3:0] dev_n;
  logic [SYNC_STAGES-1:0] warm;
  logic armed;
  logic qual;
  logic unused_adr;

  vme_sync #(.STAGES(SYNC_STAGES)) u_as (
    .FASTCLK(FASTCLK), .RST(RST), .d(AS_B), .q(as_s)
  );
  vme_sync #(.STAGES(SYNC_STAGES)) u_ds0 (
    .FASTCLK(FASTCLK), .RST(RST), .d(DS0_B), .q(ds0_s)
  );
  vme_sync #(.STAGES(SYNC_STAGES)) u_ds1 (
    .FASTCLK(FASTCLK), .RST(RST), .d(DS1_B), .q(ds1_s)
  );
  vme_sync #(.STAGES(SYNC_STAGES)) u_dtack (
    .FASTCLK(FASTCLK), .RST(RST), .d(DTACK_IN_B), .q(dtack_s)
  );

  assign as_act    = ~as_s;
  assign ds_act    = ~ds0_s | ~ds1_s;
  assign dtack_act = ~dtack_s;
  assign unused_adr = ^{ADR[18:16], ADR[1]};

  assign qual = armed & as_act & ds_act
              & (ADR[SLOT_MSB:SLOT_LSB] == GA)
              & am_ok(AM);

  assign BUSY = (state != ST_IDLE);

  // arm only once AS has been seen inactive through a flushed synchronizer
  always_ff @(posedge FASTCLK or posedge RST) begin
    if (RST) begin
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      warm  <= (warm << 1) | SYNC_STAGES'(1);
      armed <= armed | (warm[SYNC_STAGES-1] & as_s);
    end
  end

  // cycle FSM with registered outputs
  always_ff @(posedge FASTCLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      STROBE  <= 1'b0;
      DEVICE  <= '0;
      COMMAND <= '0;
      WRITE_B <= 1'b1;
      BERR_B  <= 1'b1;
      cnt     <= '0;
      dev_n   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (qual) begin
            state   <= ST_LATCH;
            COMMAND <= ADR[CMD_MSB:CMD_LSB];
            dev_n   <= ADR[DEV_MSB:DEV_LSB];
            WRITE_B <= VME_WRITE_B;
          end
        end
        ST_LATCH: begin
          if (!as_act) begin
            state <= ST_RELEASE;
          end else begin
            state  <= ST_STRB;
            STROBE <= 1'b1;
            DEVICE <= 16'd1 << dev_n;
            cnt    <= '0;
          end
        end
        ST_STRB: begin
          if (!as_act) begin
            state  <= ST_RELEASE;
            STROBE <= 1'b0;
            DEVICE <= '0;
          end else if (dtack_act) begin
            state <= ST_ACK;
          end else if (cnt == TO_LAST) begin
            state  <= ST_BERR;
            STROBE <= 1'b0;
            DEVICE <= '0;
            BERR_B <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_ACK: begin
          if (!ds_act) begin
            state  <= ST_RELEASE;
            STROBE <= 1'b0;
            DEVICE <= '0;
          end
        end
        ST_BERR: begin
          if (!ds_act) begin
            state  <= ST_RELEASE;
            BERR_B <= 1'b1;
          end
        end
        ST_RELEASE: begin
          STROBE <= 1'b0;
          DEVICE <= '0;
          BERR_B <= 1'b1;
          if (!as_act) state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          STROBE <= 1'b0;
          DEVICE <= '0;
          BERR_B <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vme_slave_decode.sv
// Directed and randomized VME cycles against a rule-level model
// of slot/AM qualification, DTACK handoff and bus-error timeout.
module tb_vme_slave_decode;

  localparam int T = 20;
  localparam int S = 2;

  logic        FASTCLK = 1'b0;
  logic        RST;
  logic [4:0]  GA;
  logic        AS_B, DS0_B, DS1_B, VME_WRITE_B, DTACK_IN_B;
  logic [5:0]  AM;
  logic [23:1] ADR;
  logic        STROBE, WRITE_B, BERR_B, BUSY;
  logic [15:0] DEVICE;
  logic [9:0]  COMMAND;

  int checks = 0;
  int errors = 0;

  vme_slave_decode #(.TIMEOUT_CYC(T), .SYNC_STAGES(S)) dut (
    .FASTCLK(FASTCLK), .RST(RST), .GA(GA),
    .AS_B(AS_B), .DS0_B(DS0_B), .DS1_B(DS1_B),
    .VME_WRITE_B(VME_WRITE_B), .AM(AM), .ADR(ADR),
    .DTACK_IN_B(DTACK_IN_B), .STROBE(STROBE), .WRITE_B(WRITE_B),
    .DEVICE(DEVICE), .COMMAND(COMMAND), .BERR_B(BERR_B), .BUSY(BUSY)
  );

  always #5 FASTCLK = ~FASTCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge FASTCLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strobe"}, STROBE, 0);
    chk({tag, "_device"}, DEVICE, 0);
    chk({tag, "_command"}, COMMAND, 0);
    chk({tag, "_write_b"}, WRITE_B, 1);
    chk({tag, "_berr_b"}, BERR_B, 1);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  task automatic set_adr(input logic [4:0] slot, input logic [3:0] dev,
                         input logic [9:0] cmd);
    ADR = {slot, 3'($urandom), dev, cmd, 1'($urandom)};
  endtask

  // wait for STROBE; returns cycle index of first BUSY and of STROBE
  task automatic wait_strobe(output int busy_k, output int strb_k);
    busy_k = -1;
    strb_k = -1;
    for (int k = 0; k < 12 && strb_k < 0; k++) begin
      @(negedge FASTCLK);
      if (BUSY && busy_k < 0) busy_k = k;
      if (STROBE) strb_k = k;
    end
  endtask

  // one full VME cycle; dt = DTACK delay after STROBE seen, -1 none
  task automatic txn(input logic [4:0] slot, input logic [5:0] am,
                     input logic [3:0] dev, input logic [9:0] cmd,
                     input logic wr, input int dt,
                     input logic [1:0] dsel);
    bit resp, exp_ack, act, drop, ok;
    int busy_k, strb_k, berr_k;
    resp = (slot == GA) && (am == 6'h39 || am == 6'h3D);
    exp_ack = (dt >= 0) && (dt <= T - 1 - S);
    set_adr(slot, dev, cmd);
    AM = am;
    VME_WRITE_B = wr;
    AS_B = 1'b0;
    DS0_B = ~dsel[0];
    DS1_B = ~dsel[1];
    if (!resp) begin
      act = 0;
      repeat (20) begin
        @(negedge FASTCLK);
        if (BUSY || STROBE || DEVICE != 0 || BERR_B !== 1'b1) act = 1;
      end
      chk("no_response", act, 0);
    end else begin
      wait_strobe(busy_k, strb_k);
      chk("strobe_rise", strb_k >= 0, 1);
      if (strb_k >= 0) begin
        chk("latch_to_strobe", strb_k - busy_k, 1);
        chk("device", DEVICE, 32'd1 << dev);
        chk("command", COMMAND, cmd);
        chk("write_b", WRITE_B, wr);
        berr_k = -1;
        drop = 0;
        if (dt == 0) DTACK_IN_B = 1'b0;
        for (int k = 1; k <= T + 6; k++) begin
          @(negedge FASTCLK);
          if (!BERR_B && berr_k < 0) begin
            berr_k = k;
            chk("berr_strobe_low", STROBE, 0);
            chk("berr_device_zero", DEVICE, 0);
          end
          if (berr_k < 0 && !STROBE) drop = 1;
          if (k == dt) DTACK_IN_B = 1'b0;
        end
        if (exp_ack) begin
          chk("ack_no_berr", berr_k, -1);
          chk("ack_strobe_held", drop, 0);
          chk("ack_device_held", DEVICE, 32'd1 << dev);
        end else begin
          chk("timeout_cycles", berr_k, T);
          chk("berr_held", BERR_B, 0);
        end
        chk("cmd_hold", COMMAND, cmd);
        DS0_B = 1'b1;
        DS1_B = 1'b1;
        ok = 0;
        for (int k = 0; k < 8 && !ok; k++) begin
          @(negedge FASTCLK);
          ok = !STROBE && BERR_B && DEVICE == 0;
        end
        chk("ds_release", ok, 1);
        cyc(2);
        chk("release_wait_as", BUSY, 1);
        chk("wr_hold", WRITE_B, wr);
      end
    end
    DTACK_IN_B = 1'b1;
    AS_B = 1'b1;
    DS0_B = 1'b1;
    DS1_B = 1'b1;
    ok = 0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge FASTCLK);
      ok = !BUSY;
    end
    chk("as_release_idle", ok, 1);
    cyc(3);
  endtask

  int bk, sk;
  bit act, ok;
  logic [4:0] r_slot;
  logic [5:0] r_am;
  int r_dt;

  initial begin
    GA = 5'd5;
    AM = 6'h39;
    ADR = '0;
    VME_WRITE_B = 1'b1;
    AS_B = 1'b1;
    DS0_B = 1'b1;
    DS1_B = 1'b1;
    DTACK_IN_B = 1'b1;
    RST = 1'b1;
    cyc(2);
    chk_reset_vals("reset");
    RST = 1'b0;
    cyc(4);

    // basic read with DTACK two cycles after STROBE
    txn(5'd5, 6'h39, 4'd3, 10'h000, 1'b1, 2, 2'b01);
    // slot mismatch
    txn(5'd6, 6'h39, 4'd3, 10'h000, 1'b1, 2, 2'b01);
    // no DTACK: bus error timeout
    txn(5'd5, 6'h3D, 4'd9, 10'h2A5, 1'b0, -1, 2'b11);
    // unsupported AM
    txn(5'd5, 6'h29, 4'd3, 10'h000, 1'b1, 2, 2'b01);
    // DTACK exactly at timeout wins, one cycle later loses
    txn(5'd5, 6'h39, 4'd15, 10'h3FF, 1'b0, T - 1 - S, 2'b10);
    txn(5'd5, 6'h39, 4'd0, 10'h155, 1'b1, T - S, 2'b01);

    // aborted cycle: AS dropped one cycle after STROBE
    set_adr(5'd5, 4'd7, 10'h0F0);
    AM = 6'h39;
    AS_B = 1'b0;
    DS0_B = 1'b0;
    wait_strobe(bk, sk);
    chk("abort_strobe_rise", sk >= 0, 1);
    @(negedge FASTCLK);
    AS_B = 1'b1;
    ok = 0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge FASTCLK);
      ok = !STROBE;
    end
    chk("abort_strobe_drop", ok, 1);
    chk("abort_device", DEVICE, 0);
    chk("abort_busy_release", BUSY, 1);
    @(negedge FASTCLK);
    chk("abort_idle_next", BUSY, 0);
    DS0_B = 1'b1;
    cyc(4);

    // reset while in ACK with the VME cycle still active
    set_adr(5'd5, 4'd12, 10'h1C3);
    VME_WRITE_B = 1'b0;
    AS_B = 1'b0;
    DS1_B = 1'b0;
    wait_strobe(bk, sk);
    chk("rst_strobe_rise", sk >= 0, 1);
    DTACK_IN_B = 1'b0;
    cyc(5);
    chk("rst_in_ack", STROBE, 1);
    #2;
    RST = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    @(negedge FASTCLK);
    RST = 1'b0;
    DTACK_IN_B = 1'b1;
    act = 0;
    repeat (15) begin
      @(negedge FASTCLK);
      if (STROBE || BUSY) act = 1;
    end
    chk("rst_no_restart", act, 0);
    AS_B = 1'b1;
    cyc(4);
    AS_B = 1'b0;
    wait_strobe(bk, sk);
    chk("rst_restart_after_as", sk >= 0, 1);
    DTACK_IN_B = 1'b0;
    cyc(3);
    DS1_B = 1'b1;
    AS_B = 1'b1;
    DTACK_IN_B = 1'b1;
    cyc(8);
    chk("rst_final_idle", BUSY, 0);

    // randomized cycles
    for (int i = 0; i < 40; i++) begin
      r_slot = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd5;
      case ($urandom_range(0, 3))
        0: r_am = 6'h39;
        1: r_am = 6'h3D;
        2: r_am = 6'($urandom);
        default: r_am = 6'h39;
      endcase
      r_dt = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, T + 3);
      txn(r_slot, r_am, 4'($urandom), 10'($urandom), 1'($urandom),
          r_dt, 2'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
